// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor and its optional BTB.
package bp_pkg;

   typedef enum logic {BP_INIT, BP_RUN} bp_state_e;

   // The tag field is sized for the smallest BTB; only the upper pc bits land in it.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
   } btb_entry_t;

   function automatic int unsigned weak_nt(input int unsigned ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one lookup port, one write port, one valid-clear port.
module bp_btb
   import bp_pkg::*;
#(
   parameter int BTB_SIZE = 64,
   parameter int BIDX_W   = $clog2(BTB_SIZE)
) (
   input  logic              clk,
   input  logic              clr_en,
   input  logic [BIDX_W-1:0] clr_idx,
   input  logic [31:0]       lookup_pc,
   output logic              hit,
   output logic [31:0]       target,
   input  logic              wr_en,
   input  logic [31:0]       wr_pc,
   input  logic [31:0]       wr_target
);

   btb_entry_t entries_q [BTB_SIZE];

   logic [BIDX_W-1:0] lk_idx;
   logic [BIDX_W-1:0] wr_idx;
   logic [31:0]       lk_tag;
   logic [31:0]       wr_tag;
   btb_entry_t        lk_entry;

   assign lk_idx   = lookup_pc[BIDX_W+1:2];
   assign wr_idx   = wr_pc[BIDX_W+1:2];
   assign lk_tag   = lookup_pc >> (BIDX_W + 2);
   assign wr_tag   = wr_pc >> (BIDX_W + 2);
   assign lk_entry = entries_q[lk_idx];

   // Lookup reads the pre-edge array, so a same-cycle write is not visible yet.
   assign hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
   assign target = hit ? lk_entry.target : 32'h0;

   always_ff @(posedge clk) begin
      if (clr_en) begin
         entries_q[clr_idx].valid <= 1'b0;
      end else if (wr_en) begin
         entries_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target};
      end
   end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with speculative GHR and mispredict repair.
// Define BRANCH_PRED_BTB_EN to add the direct-mapped BTB (bp_btb).
module gshare_branch_predictor
   import bp_pkg::*;
#(
   parameter int TABLE_SIZE = 1024,
   parameter int CTR_W      = 2,
   parameter int HIST_LEN   = 8,
   parameter int BTB_SIZE   = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                ready,
   input  logic                query_valid,
   input  logic [31:0]         query_pc,
   output logic                pred_taken,
   output logic [HIST_LEN-1:0] pred_ghr,
   output logic [31:0]         pred_target,
   output logic                pred_target_valid,
   input  logic                update_en,
   input  logic [31:0]         update_pc,
   input  logic [HIST_LEN-1:0] update_ghr,
   input  logic                actual_taken,
   input  logic                mispredict,
   input  logic [31:0]         update_target
);

   localparam int IDX_W = $clog2(TABLE_SIZE);
`ifdef BRANCH_PRED_BTB_EN
   localparam int SWEEP = (TABLE_SIZE > BTB_SIZE) ? TABLE_SIZE : BTB_SIZE;
`else
   localparam int SWEEP = TABLE_SIZE;
`endif
   localparam int SW_W = $clog2(SWEEP) + 1;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(weak_nt(CTR_W));

   bp_state_e           state_q, state_d;
   logic [SW_W-1:0]     sweep_cnt_q, sweep_cnt_d;
   logic                ready_q, ready_d;
   logic [HIST_LEN-1:0] ghr_q, ghr_d;

   logic [CTR_W-1:0]    pht_q [TABLE_SIZE];
   logic                pht_we;
   logic [IDX_W-1:0]    pht_waddr;
   logic [CTR_W-1:0]    pht_wdata;

   logic                running;
   logic                last_sweep;
   logic [IDX_W-1:0]    query_idx;
   logic [IDX_W-1:0]    update_idx;
   logic [CTR_W-1:0]    upd_ctr;

   assign running    = (state_q == BP_RUN);
   assign last_sweep = (sweep_cnt_q == SW_W'(SWEEP - 1));
   assign query_idx  = query_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign update_idx = update_pc[IDX_W+1:2] ^ IDX_W'(update_ghr);
   assign upd_ctr    = pht_q[update_idx];

   assign ready      = ready_q;
   assign pred_taken = running && pht_q[query_idx][CTR_W-1];
   assign pred_ghr   = running ? ghr_q : '0;

   always_comb begin
      state_d     = state_q;
      sweep_cnt_d = sweep_cnt_q;
      ready_d     = ready_q;
      case (state_q)
         BP_INIT: begin
            sweep_cnt_d = sweep_cnt_q + SW_W'(1);
            if (last_sweep) begin
               state_d     = BP_RUN;
               ready_d     = 1'b1;
               sweep_cnt_d = '0;
            end
         end
         BP_RUN:  state_d = BP_RUN;
         default: state_d = BP_INIT;
      endcase
   end

   // Repair from the branch's own history wins over the speculative shift.
   always_comb begin
      ghr_d = ghr_q;
      if (running) begin
         if (update_en && mispredict) begin
            ghr_d = HIST_LEN'({update_ghr, actual_taken});
         end else if (query_valid) begin
            ghr_d = HIST_LEN'({ghr_q, pred_taken});
         end
      end
   end

   always_comb begin
      pht_we    = 1'b0;
      pht_waddr = update_idx;
      pht_wdata = upd_ctr;
      if (!running) begin
         pht_we    = (sweep_cnt_q < SW_W'(TABLE_SIZE));
         pht_waddr = sweep_cnt_q[IDX_W-1:0];
         pht_wdata = CTR_INIT;
      end else if (update_en) begin
         pht_we = 1'b1;
         if (actual_taken && (upd_ctr != CTR_MAX)) begin
            pht_wdata = upd_ctr + CTR_W'(1);
         end else if (!actual_taken && (upd_ctr != '0)) begin
            pht_wdata = upd_ctr - CTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BP_INIT;
         sweep_cnt_q <= '0;
         ready_q     <= 1'b0;
         ghr_q       <= '0;
      end else begin
         state_q     <= state_d;
         sweep_cnt_q <= sweep_cnt_d;
         ready_q     <= ready_d;
         ghr_q       <= ghr_d;
      end
   end

   // The table is not reset; the INIT sweep is what gives it defined contents.
   always_ff @(posedge clk) begin
      if (pht_we) begin
         pht_q[pht_waddr] <= pht_wdata;
      end
   end

`ifdef BRANCH_PRED_BTB_EN
   localparam int BIDX_W = $clog2(BTB_SIZE);

   logic        btb_hit;
   logic [31:0] btb_target;

   bp_btb #(
      .BTB_SIZE (BTB_SIZE)
   ) u_btb (
      .clk       (clk),
      .clr_en    (!running && (sweep_cnt_q < SW_W'(BTB_SIZE))),
      .clr_idx   (sweep_cnt_q[BIDX_W-1:0]),
      .lookup_pc (query_pc),
      .hit       (btb_hit),
      .target    (btb_target),
      .wr_en     (running && update_en && actual_taken),
      .wr_pc     (update_pc),
      .wr_target (update_target)
   );

   assign pred_target_valid = running && btb_hit;
   assign pred_target       = (running && btb_hit) ? btb_target : 32'h0;
`else
   logic unused_bits;

   assign unused_bits = ^{query_pc[31:IDX_W+2], query_pc[1:0], update_pc[31:IDX_W+2],
                          update_pc[1:0], update_target, (BTB_SIZE > 0)};

   assign pred_target_valid = 1'b0;
   assign pred_target       = 32'h0;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Randomized plus directed bench for gshare_branch_predictor against a counter-array model.
module tb_gshare_branch_predictor;

   localparam int TS    = 16;
   localparam int CW    = 2;
   localparam int HL    = 4;
   localparam int BS    = 16;
   localparam int BB    = $clog2(BS);
   localparam int SWEEP = 16;

   logic          clk;
   logic          rst_n;
   logic          ready;
   logic          query_valid;
   logic [31:0]   query_pc;
   logic          pred_taken;
   logic [HL-1:0] pred_ghr;
   logic [31:0]   pred_target;
   logic          pred_target_valid;
   logic          update_en;
   logic [31:0]   update_pc;
   logic [HL-1:0] update_ghr;
   logic          actual_taken;
   logic          mispredict;
   logic [31:0]   update_target;

   int n_tests;
   int n_fail;

   gshare_branch_predictor #(
      .TABLE_SIZE (TS),
      .CTR_W      (CW),
      .HIST_LEN   (HL),
      .BTB_SIZE   (BS)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ready             (ready),
      .query_valid       (query_valid),
      .query_pc          (query_pc),
      .pred_taken        (pred_taken),
      .pred_ghr          (pred_ghr),
      .pred_target       (pred_target),
      .pred_target_valid (pred_target_valid),
      .update_en         (update_en),
      .update_pc         (update_pc),
      .update_ghr        (update_ghr),
      .actual_taken      (actual_taken),
      .mispredict        (mispredict),
      .update_target     (update_target)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          m_pht [TS];
   int          m_ghr;
   bit          m_ready;
   int          m_sweep;
   bit          m_bv [BS];
   logic [31:0] m_btag [BS];
   logic [31:0] m_btgt [BS];

   // Pending resolved branches: {ghr at query, pc}.
   logic [HL+31:0] exp_q [$];

   function automatic int m_idx(input logic [31:0] pc, input int g);
      return int'((pc >> 2) & (TS - 1)) ^ g;
   endfunction

   task automatic model_reset();
      m_ghr   = 0;
      m_ready = 1'b0;
      m_sweep = 0;
      for (int i = 0; i < TS; i++) m_pht[i] = (1 << (CW - 1)) - 1;
      for (int i = 0; i < BS; i++) m_bv[i] = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Drives one cycle, checks outputs mid-cycle against the model, then advances the model.
   task automatic cyc(input bit qv, input logic [31:0] qpc, input bit ue, input logic [31:0] upc,
                      input logic [HL-1:0] ughr, input bit act, input bit mis, input logic [31:0] utgt,
                      output bit got_pred, output logic [HL-1:0] got_ghr,
                      output bit got_tv, output logic [31:0] got_tgt);
      bit            e_pred;
      logic [HL-1:0] e_ghr;
      bit            e_tv;
      logic [31:0]   e_tgt;
      int            bi;
      int            ui;
      query_valid   = qv;
      query_pc      = qpc;
      update_en     = ue;
      update_pc     = upc;
      update_ghr    = ughr;
      actual_taken  = act;
      mispredict    = mis;
      update_target = utgt;
      @(negedge clk);
      e_pred = m_ready && (m_pht[m_idx(qpc, m_ghr)] >= (1 << (CW - 1)));
      e_ghr  = m_ready ? HL'(m_ghr) : '0;
      e_tv   = 1'b0;
      e_tgt  = 32'h0;
`ifdef BRANCH_PRED_BTB_EN
      bi = int'((qpc >> 2) & (BS - 1));
      if (m_ready && m_bv[bi] && (m_btag[bi] == (qpc >> (BB + 2)))) begin
         e_tv  = 1'b1;
         e_tgt = m_btgt[bi];
      end
`endif
      got_pred = pred_taken;
      got_ghr  = pred_ghr;
      got_tv   = pred_target_valid;
      got_tgt  = pred_target;
      check("ready", ready, m_ready);
      check("pred_taken", pred_taken, e_pred);
      check("pred_ghr", pred_ghr, e_ghr);
      check("pred_target_valid", pred_target_valid, e_tv);
      check("pred_target", pred_target, e_tgt);
      if (m_ready) begin
         if (ue) begin
            ui = m_idx(upc, int'(ughr));
            if (act) m_pht[ui] = (m_pht[ui] == (1 << CW) - 1) ? m_pht[ui] : m_pht[ui] + 1;
            else     m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
`ifdef BRANCH_PRED_BTB_EN
            if (act) begin
               bi         = int'((upc >> 2) & (BS - 1));
               m_bv[bi]   = 1'b1;
               m_btag[bi] = upc >> (BB + 2);
               m_btgt[bi] = utgt;
            end
`endif
         end
         if (ue && mis)  m_ghr = ((int'(ughr) << 1) | int'(act)) & ((1 << HL) - 1);
         else if (qv)    m_ghr = ((m_ghr << 1) | int'(e_pred)) & ((1 << HL) - 1);
      end else begin
         m_sweep++;
         if (m_sweep == SWEEP) m_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      exp_q.delete();
      #2;
      check("reset_ready", ready, 1'b0);
      check("reset_pred", pred_taken, 1'b0);
      check("reset_ghr", pred_ghr, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic rand_cycle(input bit ue_allowed);
      bit             p;
      bit             tv;
      logic [HL-1:0]  g;
      logic [31:0]    t;
      bit             qv;
      bit             ue;
      logic [31:0]    qpc;
      logic [31:0]    upc;
      logic [HL-1:0]  ughr;
      logic [HL+31:0] e;
      qv   = 1'($urandom_range(0, 1));
      qpc  = 32'($urandom_range(0, 1023)) << 2;
      ue   = ue_allowed && ($urandom_range(0, 1) == 1);
      upc  = 32'($urandom_range(0, 1023)) << 2;
      ughr = HL'($urandom_range(0, (1 << HL) - 1));
      if (ue && (exp_q.size() > 0) && ($urandom_range(0, 3) != 0)) begin
         e    = exp_q.pop_front();
         upc  = e[31:0];
         ughr = e[HL+31:32];
      end
      if (qv && m_ready && (exp_q.size() < 8)) exp_q.push_back({HL'(m_ghr), qpc});
      cyc(qv, qpc, ue, upc, ughr, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          $urandom, p, g, tv, t);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit            p;
      bit            tv;
      logic [HL-1:0] g;
      logic [31:0]   t;
      int            waited;
      n_tests       = 0;
      n_fail        = 0;
      query_valid   = 1'b0;
      query_pc      = 32'h0;
      update_en     = 1'b0;
      update_pc     = 32'h0;
      update_ghr    = '0;
      actual_taken  = 1'b0;
      mispredict    = 1'b0;
      update_target = 32'h0;
      rst_n         = 1'b0;
      @(posedge clk);
      #1;

      // Reset, abort the sweep part-way, then let a full sweep run with traffic on the inputs.
      do_reset();
      for (int c = 0; c < 5; c++) rand_cycle(1'b1);
      do_reset();
      waited = 0;
      while (!ready && waited < 100) begin
         rand_cycle(1'b1);
         waited++;
      end
      check("sweep_cycles", waited, SWEEP);

      // Counter saturation on one index with history 0.
      for (int c = 0; c < 3; c++) cyc(0, 32'h40, 1, 32'h40, '0, 1, 0, 32'h0, p, g, tv, t);
      cyc(0, 32'h40, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("sat_taken", p, 1'b1);
      cyc(0, 32'h40, 1, 32'h40, '0, 0, 0, 32'h0, p, g, tv, t);
      cyc(0, 32'h40, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("dec_still_taken", p, 1'b1);

      // Same pc, different history lands on a separate counter.
      for (int c = 0; c < 2; c++) cyc(0, 32'h40, 1, 32'h40, HL'(1), 0, 0, 32'h0, p, g, tv, t);
      cyc(1, 32'h40, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("ghr0_pred", p, 1'b1);
      cyc(0, 32'h40, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("ghr1_pred", p, 1'b0);
      check("ghr1_value", g, HL'(1));

      // Repair beats a same-cycle speculative shift.
      cyc(0, 32'h0, 1, 32'h80, HL'(2), 1, 1, 32'h0, p, g, tv, t);
      cyc(1, 32'h14, 1, 32'h80, HL'(2), 0, 1, 32'h0, p, g, tv, t);
      check("repair_pred", p, 1'b1);
      check("repair_ghr_before", g, HL'(5));
      cyc(0, 32'h0, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("repair_ghr_after", g, HL'(4));

      // Read-before-write on a shared index.
      cyc(0, 32'h1C, 1, 32'h1C, HL'(4), 1, 0, 32'h0, p, g, tv, t);
      check("rbw_old", p, 1'b0);
      cyc(0, 32'h1C, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("rbw_new", p, 1'b1);

`ifdef BRANCH_PRED_BTB_EN
      cyc(0, 32'h100, 1, 32'h100, '0, 1, 0, 32'h2000, p, g, tv, t);
      cyc(0, 32'h100, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("btb_hit", tv, 1'b1);
      check("btb_target", t, 32'h2000);
      cyc(0, 32'h140, 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
      check("btb_alias_miss", tv, 1'b0);
`endif

      // Reset mid-run: everything back to its swept state.
      do_reset();
      waited = 0;
      while (!ready && waited < 100) begin
         rand_cycle(1'b0);
         waited++;
      end
      check("resweep_cycles", waited, SWEEP);
      for (int b = 0; b < BS; b++) begin
         cyc(0, 32'h100 | (32'(b) << 2), 0, 32'h0, '0, 0, 0, 32'h0, p, g, tv, t);
         check("resweep_btb_miss", tv, 1'b0);
      end

      // Random traffic, with one reset in the middle.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         rand_cycle(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
